unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-port, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It sequences each access through a request/ready handshake and gives the MEM stage priority. It drives the stall signals that freeze the front end or the whole pipeline while an access is outstanding. It cancels in-flight fetches when a taken branch or jump flushes the front end.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, maximum cycles an access may wait for mem_ready before it is aborted (>= 2)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF stage wants a fetch (PCWrite-qualified)
- if_addr  in  ADDR_W  fetch address (PC)
- ex_mem_MemRead  in  1  MEM-stage load
- ex_mem_MemWrite  in  1  MEM-stage store
- ex_mem_addr  in  ADDR_W  load/store address
- ex_mem_wdata  in  DATA_W  store data
- flush  in  1  branch_or_jump_taken; cancels an in-flight fetch
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write enable, valid with mem_req
- mem_addr  out  ADDR_W  memory address, valid with mem_req
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  one-cycle completion strobe from memory
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- if_valid  out  1  one-cycle pulse: if_rdata holds the requested instruction
- if_rdata  out  DATA_W  fetched instruction, holds the last value
- mem_done  out  1  one-cycle pulse: load/store complete
- mem_rdata_out  out  DATA_W  load data, holds the last value
- stall_if  out  1  hold PC and IF/ID
- stall_all  out  1  freeze all pipeline registers
- mem_err  out  1  sticky timeout flag

## Operation
- States: IDLE, IF_BUSY, MEM_BUSY. mem_req = (state != IDLE), registered.
- IDLE, issue rule, evaluated each edge:
  - MEM request (MemRead|MemWrite) with mem_done low → MEM_BUSY. Latch addr, wdata and we = MemWrite.
  - Otherwise, if_req with if_valid low and flush low → IF_BUSY. Latch if_addr, we = 0.
  - A requester whose done pulse is high this cycle is not reissued, because that pulse is its own just-completed access. The other requester may issue.
- IF_BUSY:
  - flush high on any cycle sets a drop flag.
  - On mem_ready → IDLE. If not dropped: capture if_rdata and pulse if_valid. If dropped: discard the data, no pulse, clear the flag.
- MEM_BUSY:
  - On mem_ready → IDLE. Pulse mem_done. For loads, capture mem_rdata_out; for stores, it is unchanged.
  - flush is ignored; MEM accesses are never cancelled.
- Priority: MEM over IF only at issue. A busy IF access is never preempted; a MEM request waits for it to finish.
- Timeout: the wait counter resets on issue and increments each busy cycle without mem_ready. When the count reaches TIMEOUT → IDLE and set mem_err. Pulse the done signal of the aborted requester with data 0 (no pulse for a dropped fetch). mem_err clears only on rst.
- mem_ready while IDLE is ignored.
- Stalls, combinational:
  - stall_all = (MemRead|MemWrite) & ~mem_done.
  - stall_if = stall_all | (if_req & ~if_valid).
- if_valid and flush in the same cycle: if_valid still pulses; the pipeline's IF flush discards the instruction.

## Timing
- Reset values: state IDLE, mem_req/mem_we/if_valid/mem_done/mem_err 0, mem_addr/mem_wdata/if_rdata/mem_rdata_out 0, drop flag and counter 0.
- Access latency: request seen at edge 0. mem_req is high from cycle 1. If mem_ready arrives in cycle k (k ≥ 1), the done pulse and data are in cycle k+1 and mem_req is low in cycle k+1. The minimum is 2 cycles from request to done.
- The next issue can occur at the edge ending the done cycle, so there is at least one IDLE cycle between accesses.
- mem_addr, mem_we and mem_wdata are stable for the whole mem_req assertion.
- Reset mid-access: mem_req drops at the reset edge. A late mem_ready is ignored, and no done pulse is produced.

## Test plan
- Fetch only: if_req=1, if_addr=0x40, mem_ready in cycle 3 with rdata 0x8C220004 → if_valid pulse in cycle 4 with if_rdata=0x8C220004. stall_if is high in cycles 0–3 and low in cycle 4.
- Collision: if_req and MemRead (addr 0x1000) both high in IDLE → MEM issues first with stall_all high. After mem_done, the fetch issues. mem_rdata_out=0x1234 from the ready data.
- Flush: flush pulses during IF_BUSY → no if_valid on the next mem_ready. A new fetch issues afterwards. The flush has no effect when injected during MEM_BUSY.
- Store: MemWrite, addr 0x2000, wdata 0xDEADBEEF → mem_we=1 with stable addr/data until ready. mem_done pulses and mem_rdata_out is unchanged.
- Timeout: TIMEOUT=4 with mem_ready never asserted → return to IDLE after 4 busy cycles, mem_done with data 0, mem_err stays 1 until rst.
- Reset mid-MEM_BUSY: rst high for 1 cycle → mem_req is 0 the next cycle. A stale mem_ready produces no pulse. All outputs are at their reset values.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port, variable-latency memory between
// the IF stage (fetch) and the MEM stage (load/store). MEM wins at issue, a busy
// access is never preempted, fetches can be cancelled by a front-end flush, and
// every access is bounded by a TIMEOUT-cycle watchdog that sets a sticky error.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              ex_mem_MemRead,
  input  logic              ex_mem_MemWrite,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic              stall_if,
  output logic              stall_all,
  output logic              mem_err
);

  // TIMEOUT >= 2, so the counter only ever needs to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } state_t;

  state_t           state;
  logic             drop;
  logic [CNT_W-1:0] wait_cnt;

  logic mem_rq;
  logic drop_now;
  logic timed_out;

  // A flush arriving in the completion cycle itself still cancels the fetch.
  always_comb begin
    mem_rq    = ex_mem_MemRead | ex_mem_MemWrite;
    drop_now  = drop | flush;
    timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
    stall_all = mem_rq & ~mem_done;
    stall_if  = stall_all | (if_req & ~if_valid);
  end

  // Access sequencer: issue, wait for mem_ready or timeout, deliver result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      drop          <= 1'b0;
      wait_cnt      <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      if_valid      <= 1'b0;
      if_rdata      <= '0;
      mem_done      <= 1'b0;
      mem_rdata_out <= '0;
      mem_err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          // A requester whose done pulse is high is not reissued this edge.
          if (mem_rq && !mem_done) begin
            state     <= MEM_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= ex_mem_MemWrite;
            mem_addr  <= ex_mem_addr;
            mem_wdata <= ex_mem_wdata;
            wait_cnt  <= '0;
          end else if (if_req && !if_valid && !flush) begin
            state    <= IF_BUSY;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            wait_cnt <= '0;
            drop     <= 1'b0;
          end
        end
        IF_BUSY: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            drop    <= 1'b0;
            if (!drop_now) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (timed_out) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            drop    <= 1'b0;
            mem_err <= 1'b1;
            if (!drop_now) begin
              if_valid <= 1'b1;
              if_rdata <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            drop     <= drop_now;
          end
        end
        MEM_BUSY: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_done <= 1'b1;
            if (!mem_we) mem_rdata_out <= mem_rdata;
          end else if (timed_out) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            mem_done      <= 1'b1;
            mem_rdata_out <= '0;
            mem_err       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        rd;
  logic        wr;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        mem_done;
  logic [31:0] mem_rdata_out;
  logic        stall_if;
  logic        stall_all;
  logic        mem_err;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .ex_mem_MemRead (rd),
    .ex_mem_MemWrite(wr),
    .ex_mem_addr    (ex_addr),
    .ex_mem_wdata   (ex_wdata),
    .flush          (flush),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .if_valid       (if_valid),
    .if_rdata       (if_rdata),
    .mem_done       (mem_done),
    .mem_rdata_out  (mem_rdata_out),
    .stall_if       (stall_if),
    .stall_all      (stall_all),
    .mem_err        (mem_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the one outstanding access (owner 0 = none, 1 = fetch, 2 = load/store)
  // plus the visible result registers.
  int          m_owner;
  int          m_age;
  logic        m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic        m_ifv;
  logic [31:0] m_if_rdata;
  logic        m_done;
  logic [31:0] m_rdata_out;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_drop = 1'b0;
    m_addr = '0; m_wdata = '0; m_we = 1'b0;
    m_ifv = 1'b0; m_if_rdata = '0; m_done = 1'b0; m_rdata_out = '0; m_err = 1'b0;
  endtask

  task automatic compare();
    logic exp_sa;
    logic exp_si;
    exp_sa = (rd | wr) & ~m_done;
    exp_si = exp_sa | (if_req & ~m_ifv);
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_owner != 0});
    if (m_owner != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_ifv});
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("mem_done", {31'd0, mem_done}, {31'd0, m_done});
    chk("mem_rdata_out", mem_rdata_out, m_rdata_out);
    chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
    chk("stall_all", {31'd0, stall_all}, {31'd0, exp_sa});
    chk("stall_if", {31'd0, stall_if}, {31'd0, exp_si});
  endtask

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic step();
    logic ifv_prev;
    logic done_prev;
    logic abort;
    ifv_prev  = m_ifv;
    done_prev = m_done;
    m_ifv  = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_owner == 0) begin
      if ((rd | wr) && !done_prev) begin
        m_owner = 2; m_addr = ex_addr; m_we = wr; m_wdata = ex_wdata; m_age = 0;
      end else if (if_req && !ifv_prev && !flush) begin
        m_owner = 1; m_addr = if_addr; m_we = 1'b0; m_age = 0; m_drop = 1'b0;
      end
    end else begin
      m_age++;
      abort = !mem_ready && (m_age == int'(TO));
      if (m_owner == 1 && flush) m_drop = 1'b1;
      if (mem_ready || abort) begin
        if (abort) m_err = 1'b1;
        if (m_owner == 1) begin
          if (!m_drop) begin
            m_ifv = 1'b1;
            m_if_rdata = abort ? 32'd0 : mem_rdata;
          end
          m_drop = 1'b0;
        end else begin
          m_done = 1'b1;
          if (abort) m_rdata_out = '0;
          else if (!m_we) m_rdata_out = mem_rdata;
        end
        m_owner = 0;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    compare();
  endtask

  task automatic at_pos();
    @(posedge clk);
    step();
    #1;
  endtask

  task automatic quiet();
    rst = 1'b0; if_req = 1'b0; if_addr = '0; rd = 1'b0; wr = 1'b0;
    ex_addr = '0; ex_wdata = '0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic idle_cycle();
    at_neg();
    at_pos();
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    model_reset();
    at_pos();

    // Reset state
    at_neg();
    at_pos();
    rst = 1'b0;
    at_neg();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    at_pos();

    // Fetch only: ready in cycle 3, if_valid in cycle 4
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 0; c <= 4; c++) begin
      mem_ready = (c == 3);
      mem_rdata = (c == 3) ? 32'h8C220004 : 32'd0;
      at_neg();
      chk("fetch_stall_if", {31'd0, stall_if}, (c < 4) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 3) chk("fetch_mem_req", {31'd0, mem_req}, 32'd1);
      if (c == 4) begin
        chk("fetch_if_valid", {31'd0, if_valid}, 32'd1);
        chk("fetch_if_rdata", if_rdata, 32'h8C220004);
      end
      at_pos();
    end
    quiet();
    idle_cycle();

    // Collision: MEM issues first, fetch follows after mem_done
    if_req = 1'b1; if_addr = 32'h40; rd = 1'b1; ex_addr = 32'h1000;
    at_neg(); chk("col_stall_all", {31'd0, stall_all}, 32'd1); at_pos();
    at_neg(); chk("col_addr", mem_addr, 32'h1000); chk("col_we", {31'd0, mem_we}, 32'd0); at_pos();
    mem_ready = 1'b1; mem_rdata = 32'h1234;
    at_neg(); at_pos();
    mem_ready = 1'b0; mem_rdata = '0;
    at_neg();
    chk("col_done", {31'd0, mem_done}, 32'd1);
    chk("col_rdata", mem_rdata_out, 32'h1234);
    chk("col_stall_all_off", {31'd0, stall_all}, 32'd0);
    at_pos();
    rd = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hAAAA0001;
    at_neg(); chk("col_fetch_req", {31'd0, mem_req}, 32'd1); chk("col_fetch_addr", mem_addr, 32'h40); at_pos();
    mem_ready = 1'b0;
    at_neg(); chk("col_fetch_valid", {31'd0, if_valid}, 32'd1); at_pos();
    quiet();
    idle_cycle();

    // Flush during IF_BUSY drops the fetch; a new fetch issues afterwards
    if_req = 1'b1; if_addr = 32'h80;
    idle_cycle();
    flush = 1'b1;
    idle_cycle();
    flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11111111;
    idle_cycle();
    mem_ready = 1'b0;
    at_neg(); chk("flush_no_valid", {31'd0, if_valid}, 32'd0); at_pos();
    mem_ready = 1'b1; mem_rdata = 32'h22222222;
    at_neg(); chk("flush_reissue", {31'd0, mem_req}, 32'd1); at_pos();
    mem_ready = 1'b0;
    at_neg(); chk("flush_refetch", if_rdata, 32'h22222222); at_pos();
    quiet();
    idle_cycle();

    // Flush during MEM_BUSY has no effect
    rd = 1'b1; ex_addr = 32'h3000;
    idle_cycle();
    flush = 1'b1;
    idle_cycle();
    flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h33333333;
    idle_cycle();
    mem_ready = 1'b0;
    at_neg(); chk("mflush_done", {31'd0, mem_done}, 32'd1); chk("mflush_rdata", mem_rdata_out, 32'h33333333); at_pos();
    quiet();
    idle_cycle();

    // Store: stable addr/data while busy, load data unchanged
    wr = 1'b1; ex_addr = 32'h2000; ex_wdata = 32'hDEADBEEF;
    idle_cycle();
    for (int c = 1; c <= 3; c++) begin
      ex_addr = $urandom; ex_wdata = $urandom;
      mem_ready = (c == 3); mem_rdata = 32'h55555555;
      at_neg();
      chk("st_we", {31'd0, mem_we}, 32'd1);
      chk("st_addr", mem_addr, 32'h2000);
      chk("st_wdata", mem_wdata, 32'hDEADBEEF);
      at_pos();
    end
    mem_ready = 1'b0;
    at_neg(); chk("st_done", {31'd0, mem_done}, 32'd1); chk("st_rdata_kept", mem_rdata_out, 32'h33333333); at_pos();
    quiet();
    idle_cycle();

    // Timeout: no ready for TO busy cycles
    rd = 1'b1; ex_addr = 32'h4000;
    for (int c = 0; c <= 4; c++) begin
      at_neg();
      if (c >= 1) chk("to_busy", {31'd0, mem_req}, 32'd1);
      at_pos();
    end
    at_neg();
    chk("to_req_off", {31'd0, mem_req}, 32'd0);
    chk("to_done", {31'd0, mem_done}, 32'd1);
    chk("to_rdata", mem_rdata_out, 32'd0);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    at_pos();
    quiet();
    idle_cycle();
    at_neg(); chk("to_err_sticky", {31'd0, mem_err}, 32'd1); at_pos();

    // Reset mid-MEM_BUSY, then a stale ready
    rd = 1'b1; ex_addr = 32'h5000;
    idle_cycle();
    at_neg(); chk("rm_busy", {31'd0, mem_req}, 32'd1); at_pos();
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0; rd = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h77777777;
    at_neg();
    chk("rm_req_off", {31'd0, mem_req}, 32'd0);
    chk("rm_err_clr", {31'd0, mem_err}, 32'd0);
    chk("rm_rdata", mem_rdata_out, 32'd0);
    at_pos();
    mem_ready = 1'b0;
    at_neg(); chk("rm_no_done", {31'd0, mem_done}, 32'd0); chk("rm_no_req", {31'd0, mem_req}, 32'd0); at_pos();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      if_req    = ($urandom_range(0, 3) != 0);
      if_addr   = $urandom;
      rd        = ($urandom_range(0, 4) == 0);
      wr        = ($urandom_range(0, 5) == 0);
      ex_addr   = $urandom;
      ex_wdata  = $urandom;
      flush     = ($urandom_range(0, 6) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
